// File: rtl/conv_req_sched_if.sv
// Request/response bundle between the conversion agents and conv_req_sched.
// The master side issues requests and consumes responses.
interface conv_req_sched_if #(
    parameter int WIDTH = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_data;
    logic [1:0]         req_mode;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_id;

    modport master (
        output req_valid, req_data, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/conv_req_sched.sv
// Two-requester round-robin scheduler in front of the shared
// binary<->Gray converter; one transaction in flight at a time.
module conv_req_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_req_sched_if.slave  bus,
    output logic [WIDTH-1:0] conv_data_in,
    output logic             conv_sel,
    input  logic [WIDTH-1:0] conv_data_out,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             ptr;
    logic [1:0]       gnt;
    logic             gnt_id;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    // Grant is decided combinationally in IDLE; ptr only breaks ties.
    always_comb begin
        gnt = 2'b00;
        if (state == IDLE && rst_n) begin
            if (&bus.req_valid)
                gnt[ptr] = 1'b1;
            else
                gnt = bus.req_valid;
        end
    end

    assign gnt_id        = gnt[1];
    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            conv_data_in <= '0;
            conv_sel     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        conv_data_in <= gnt_id ? bus.req_data[2*WIDTH-1:WIDTH]
                                               : bus.req_data[WIDTH-1:0];
                        conv_sel     <= bus.req_mode[gnt_id];
                        rsp_id_q     <= gnt_id;
                        state        <= CONV;
                    end
                end
                CONV: begin
                    rsp_data_q  <= conv_data_out;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // Favour the other requester once this one is served.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr         <= ~rsp_id_q;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
